matrix_frame_arbiter: RTL and testbench

Frame-level controller for the 8x8 serial LED matrix. It arbitrates round-robin between two frame sources, each supplying a 64-pixel bitmap and two 32-bit colour words, and latches the winning frame. It then serialises that frame onto the strip clock/data pair: start frame, 64 snake-ordered LED words, end frame, then an enforced idle gap. It sits between the pattern generators (scroller, static pattern) and the chip's `io_out[1:0]` pins.

---
 rtl/matrix_frame_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_matrix_frame_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_arbiter.sv
// matrix_frame_arbiter
// Round-robin frame arbiter and serialiser for the 8x8 serial LED matrix.
// It grants one of two frame sources, latches that source's bitmap and colour
// words, then drives a start frame, 64 snake-ordered LED words, an end frame
// and an idle gap onto the strip clock/data pair.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   req[1:0]            frame request per source, held until granted
//   bitmap0/1[63:0]     pixel bitmaps, pixel i is bitmapN[63-i]
//   fg0/1[31:0]         colour word for lit pixels
//   bg0/1[31:0]         colour word for unlit pixels
//   grant[1:0]          one-hot one-cycle grant pulse (inputs latched then)
//   busy                high from the grant cycle to the last gap cycle
//   frame_done          one-cycle pulse after the last end-frame bit
//   strip_clk           LED strip clock
//   strip_data          LED strip data
module matrix_frame_arbiter #(
   parameter int unsigned GAP_CYCLES = 100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   input  logic [63:0] bitmap0,
   input  logic [63:0] bitmap1,
   input  logic [31:0] fg0,
   input  logic [31:0] fg1,
   input  logic [31:0] bg0,
   input  logic [31:0] bg1,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        frame_done,
   output logic        strip_clk,
   output logic        strip_data
);

   localparam int unsigned START_BITS = 32;
   localparam int unsigned END_BITS   = 64;
   localparam int unsigned WORD_BITS  = 32;
   localparam int unsigned NUM_LEDS   = 64;
   localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'((GAP_CYCLES == 0) ? 32'd0 : GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PIXELS,
      S_END,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [5:0]       bit_q, bit_d;
   logic [5:0]       led_q, led_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             last_q, last_d;
   logic [63:0]      bitmap_q;
   logic [31:0]      fg_q, bg_q;

   logic             latch_en;
   logic             sel;
   logic [1:0]       grant_d;
   logic             busy_d, done_d, sclk_d, sdata_d;

   logic [2:0]       row_d, col_d;
   logic [5:0]       pix_d;
   logic [31:0]      word_d;
   logic             pix_bit_d;

   // State and output registers; all outputs leave straight from flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         phase_q    <= 1'b0;
         bit_q      <= '0;
         led_q      <= '0;
         gap_q      <= '0;
         last_q     <= 1'b1;
         bitmap_q   <= '0;
         fg_q       <= '0;
         bg_q       <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         strip_clk  <= 1'b0;
         strip_data <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         led_q      <= led_d;
         gap_q      <= gap_d;
         last_q     <= last_d;
         grant      <= grant_d;
         busy       <= busy_d;
         frame_done <= done_d;
         strip_clk  <= sclk_d;
         strip_data <= sdata_d;
         if (latch_en) begin
            bitmap_q <= sel ? bitmap1 : bitmap0;
            fg_q     <= sel ? fg1 : fg0;
            bg_q     <= sel ? bg1 : bg0;
         end
      end
   end

   // Next state, counters and next output values.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      led_d    = led_q;
      gap_d    = gap_q;
      last_d   = last_q;
      latch_en = 1'b0;
      sel      = 1'b0;
      grant_d  = 2'b00;
      busy_d   = busy;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               // Contention goes to the source not granted last.
               sel      = (req == 2'b11) ? ~last_q : req[1];
               latch_en = 1'b1;
               last_d   = sel;
               grant_d  = sel ? 2'b10 : 2'b01;
               busy_d   = 1'b1;
               state_d  = S_START;
               phase_d  = 1'b0;
               bit_d    = '0;
               led_d    = '0;
            end
         end

         S_START: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (bit_q == 6'(START_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = S_PIXELS;
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end
         end

         S_PIXELS: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (bit_q == 6'(WORD_BITS - 1)) begin
                  bit_d = '0;
                  if (led_q == 6'(NUM_LEDS - 1)) begin
                     led_d   = '0;
                     state_d = S_END;
                  end else begin
                     led_d = led_q + 6'd1;
                  end
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end
         end

         S_END: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (bit_q == 6'(END_BITS - 1)) begin
                  bit_d  = '0;
                  done_d = 1'b1;
                  if (GAP_CYCLES == 0) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = S_GAP;
                     gap_d   = '0;
                  end
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Snake wiring: even rows run right-to-left across the bitmap.
      row_d     = led_d[5:3];
      col_d     = led_d[2:0];
      pix_d     = row_d[0] ? {row_d, col_d} : {row_d, ~col_d};
      word_d    = bitmap_q[~pix_d] ? fg_q : bg_q;
      pix_bit_d = word_d[~bit_d[4:0]];

      // Line levels follow the position being entered; idle and gap stay low.
      sclk_d  = (state_d inside {S_START, S_PIXELS, S_END}) && phase_d;
      sdata_d = (state_d == S_PIXELS) && pix_bit_d;
   end

endmodule

// File: tb/tb_matrix_frame_arbiter.sv
// Scoreboard bench for matrix_frame_arbiter: stimulus queues expected grants
// and 32-bit strip words, a negedge monitor pops and compares them.
module tb_matrix_frame_arbiter;

   localparam int unsigned GAP         = 100;
   localparam int          FRAME_CYC   = 4288;
   localparam int          FRAME_EDGES = 2144;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req;
   logic [63:0] bitmap0, bitmap1;
   logic [31:0] fg0, fg1, bg0, bg1;
   logic [1:0]  grant;
   logic        busy, frame_done, strip_clk, strip_data;

   logic        rst_z;
   logic [1:0]  req_z, grant_z;
   logic        busy_z, done_z, sclk_z, sdata_z;
   logic        z_done;

   always #5 clk = ~clk;

   matrix_frame_arbiter #(.GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .bitmap0    (bitmap0),
      .bitmap1    (bitmap1),
      .fg0        (fg0),
      .fg1        (fg1),
      .bg0        (bg0),
      .bg1        (bg1),
      .grant      (grant),
      .busy       (busy),
      .frame_done (frame_done),
      .strip_clk  (strip_clk),
      .strip_data (strip_data)
   );

   matrix_frame_arbiter #(.GAP_CYCLES(0)) dut_z (
      .clk        (clk),
      .reset_n    (rst_z),
      .req        (req_z),
      .bitmap0    (64'h0),
      .bitmap1    (64'h0),
      .fg0        (32'h0),
      .fg1        (32'h0),
      .bg0        (32'h1111_1111),
      .bg1        (32'h2222_2222),
      .grant      (grant_z),
      .busy       (busy_z),
      .frame_done (done_z),
      .strip_clk  (sclk_z),
      .strip_data (sdata_z)
   );

   typedef struct {
      logic [1:0] g;
      int         delta;
   } exp_grant_t;

   exp_grant_t  exp_grants[$];
   logic [31:0] exp_words[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: event missing or unexpected (got none, expected one)", name);
   endtask

   task automatic push_grant(input logic [1:0] g, input int delta);
      exp_grant_t e;
      e.g = g;
      e.delta = delta;
      exp_grants.push_back(e);
   endtask

   // Start word, 64 LED words (one optional "hot" LED), two end words.
   task automatic push_frame(input int hot, input logic [31:0] hot_word, input logic [31:0] other);
      exp_words.push_back(32'h0);
      for (int k = 0; k < 64; k++) exp_words.push_back((k == hot) ? hot_word : other);
      exp_words.push_back(32'h0);
      exp_words.push_back(32'h0);
   endtask

   task automatic wait_grant(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (grant != 2'b00) return;
      end
      fail_now(name);
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (frame_done) return;
      end
      fail_now(name);
   endtask

   // Monitor state
   int          cyc = 0;
   int          grant_cyc = 0;
   int          fd_cyc = 0;
   int          edges = 0;
   int          nbits = 0;
   int          word_idx = 0;
   logic [31:0] acc = '0;
   logic [31:0] ew;
   logic        prev_sclk = 1'b0;
   logic        in_gap = 1'b0;
   logic        lines_hi = 1'b0;
   exp_grant_t  eg;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         acc = '0; nbits = 0; edges = 0; in_gap = 1'b0; prev_sclk = 1'b0; word_idx = 0;
      end else begin
         if (grant != 2'b00) begin
            if (exp_grants.size() == 0) fail_now("unexpected_grant");
            else begin
               eg = exp_grants.pop_front();
               check("grant", 64'(grant), 64'(eg.g));
               if (eg.delta >= 0) begin
                  check("gap_delta", 64'(cyc - fd_cyc), 64'(eg.delta));
                  check("gap_lines_low", 64'(lines_hi), 64'h0);
               end
            end
            grant_cyc = cyc; edges = 0; in_gap = 1'b0; word_idx = 0;
         end
         if (in_gap && (strip_clk || strip_data)) lines_hi = 1'b1;
         if (frame_done) begin
            check("done_latency", 64'(cyc - grant_cyc), 64'(FRAME_CYC));
            check("clk_edges", 64'(edges), 64'(FRAME_EDGES));
            check("busy_at_done", 64'(busy), 64'h1);
            fd_cyc = cyc; in_gap = 1'b1; lines_hi = 1'b0;
         end
         if (strip_clk && !prev_sclk) begin
            edges++;
            acc = {acc[30:0], strip_data};
            nbits++;
            if (nbits == 32) begin
               if (exp_words.size() == 0) fail_now("unexpected_word");
               else begin
                  ew = exp_words.pop_front();
                  check($sformatf("word%0d", word_idx), 64'(acc), 64'(ew));
               end
               nbits = 0;
               word_idx++;
            end
         end
         prev_sclk = strip_clk;
      end
   end

   // Zero-gap instance: next grant one cycle after frame_done.
   initial begin : zero_gap
      int n, tg, tf, tg2;
      rst_z = 1'b0; req_z = 2'b00; z_done = 1'b0;
      repeat (3) @(negedge clk);
      rst_z = 1'b1; req_z = 2'b01;
      n = 0; tg = -1; tf = -1; tg2 = -1;
      while (n < 9000 && tg2 < 0) begin
         @(negedge clk);
         n++;
         if (tg < 0 && grant_z != 2'b00) begin
            tg = n;
            check("z_first_grant", 64'(grant_z), 64'h1);
         end else if (tg >= 0 && tf < 0 && done_z) begin
            tf = n;
            check("z_done_latency", 64'(tf - tg), 64'(FRAME_CYC));
            check("z_busy_at_done", 64'(busy_z), 64'h0);
            check("z_no_overlap", 64'(grant_z), 64'h0);
            check("z_lines_idle", 64'({sclk_z, sdata_z}), 64'h0);
         end else if (tf >= 0 && grant_z != 2'b00) begin
            tg2 = n;
            check("z_regrant_delta", 64'(tg2 - tf), 64'h1);
         end
      end
      if (tg2 < 0) fail_now("z_regrant");
      req_z = 2'b00;
      z_done = 1'b1;
   end

   initial begin : stimulus
      reset_n = 1'b0; req = 2'b00;
      bitmap0 = '0; bitmap1 = '0; fg0 = '0; fg1 = '0; bg0 = '0; bg1 = '0;
      repeat (3) @(negedge clk);
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(frame_done), 64'h0);
      check("rst_sclk", 64'(strip_clk), 64'h0);
      check("rst_sdata", 64'(strip_data), 64'h0);
      reset_n = 1'b1;

      // Single lit pixel 7 lands on LED0.
      bitmap0 = 64'h0100_0000_0000_0000; fg0 = 32'hFFFF_FFFF; bg0 = 32'h0;
      push_grant(2'b01, -1);
      push_frame(0, 32'hFFFF_FFFF, 32'h0);
      req = 2'b01;
      wait_grant(10, "t1_grant");
      req = 2'b00;
      wait_done(4400, "t1_done");

      // Pixel 8 lands on LED8 (odd row runs left-to-right).
      bitmap0 = 64'h0080_0000_0000_0000; fg0 = 32'hE0FF_0000; bg0 = 32'hE000_0000;
      push_grant(2'b01, -1);
      push_frame(8, 32'hE0FF_0000, 32'hE000_0000);
      req = 2'b01;
      wait_grant(300, "t2_grant");
      req = 2'b00;
      wait_done(4400, "t2_done");

      // Pixel 0 lands on LED7; inputs change after the grant and must not leak.
      bitmap0 = 64'h8000_0000_0000_0000; fg0 = 32'hCAFE_F00D; bg0 = 32'h0;
      push_grant(2'b01, -1);
      push_frame(7, 32'hCAFE_F00D, 32'h0);
      req = 2'b01;
      wait_grant(300, "t3_grant");
      req = 2'b00;
      @(negedge clk);
      bitmap0 = '1; fg0 = 32'hFFFF_FFFF;
      wait_done(4400, "t3_done");

      // Both sources requesting from reset, then source 1 alone twice.
      reset_n = 1'b0; req = 2'b11;
      bitmap0 = '1;   fg0 = 32'hA5A5_A5A5; bg0 = 32'h0;
      bitmap1 = '0;   fg1 = 32'hFFFF_FFFF; bg1 = 32'h5A5A_C3C3;
      push_grant(2'b01, -1);  push_frame(-1, 32'h0, 32'hA5A5_A5A5);
      push_grant(2'b10, 101); push_frame(-1, 32'h0, 32'h5A5A_C3C3);
      push_grant(2'b01, 101); push_frame(-1, 32'h0, 32'hA5A5_A5A5);
      push_grant(2'b10, 101); push_frame(-1, 32'h0, 32'h5A5A_C3C3);
      push_grant(2'b10, 101); push_frame(-1, 32'h0, 32'h5A5A_C3C3);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_grant(10, "arb_g1");
      wait_done(4400, "arb_d1");
      wait_grant(300, "arb_g2");
      wait_done(4400, "arb_d2");
      wait_grant(300, "arb_g3");
      req = 2'b10;
      wait_done(4400, "arb_d3");
      wait_grant(300, "arb_g4");
      wait_done(4400, "arb_d4");
      wait_grant(300, "arb_g5");

      // Asynchronous reset mid-PIXELS with source 0 requesting.
      req = 2'b01;
      repeat (200) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_grant", 64'(grant), 64'h0);
      check("mid_rst_busy", 64'(busy), 64'h0);
      check("mid_rst_done", 64'(frame_done), 64'h0);
      check("mid_rst_sclk", 64'(strip_clk), 64'h0);
      check("mid_rst_sdata", 64'(strip_data), 64'h0);
      exp_words.delete();
      push_grant(2'b01, -1);
      push_frame(-1, 32'h0, 32'hA5A5_A5A5);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("grant_after_reset", 64'(grant), 64'h1);
      req = 2'b00;
      wait_done(4400, "rst_frame_done");

      for (int i = 0; i < 20000 && !z_done; i++) @(negedge clk);
      if (!z_done) fail_now("z_finish");
      check("words_drained", 64'(exp_words.size()), 64'h0);
      check("grants_drained", 64'(exp_grants.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
